// File: rtl/beamformer_pkg.sv
// Shared constants and types for the 4-channel beamformer datapath.
// Lane k of a multi-lane bus carries channel CHxx where CHxx == k.
package beamformer_pkg;

  localparam int SDATA_WIDTH   = 128;
  localparam int SSAMPLE_WIDTH = 16;
  localparam int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH;
  localparam int NUM_CH        = 4;
  localparam int TKEEP_WIDTH   = SDATA_WIDTH / 8;

  localparam int CH00 = 0;
  localparam int CH01 = 1;
  localparam int CH20 = 2;
  localparam int CH21 = 3;

  localparam logic [TKEEP_WIDTH-1:0] TKEEP_ALL_ONES = '1;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_BUSY
  } frame_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream buffer (data + tlast) with a registered not_full flag.
// not_full only reflects the stored count, so upstream ready never depends on m_ready.
module axis_skid_buffer #(
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              not_full
);

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [1:0]        last_q, last_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              not_full_q, not_full_d;
  logic              push, pop;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    data_d     = data_q;
    last_d     = last_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    pop  = (count_q != 2'd0) && m_ready;
    push = s_valid && ((count_q != 2'd2) || pop);

    if (push) begin
      data_d[wr_ptr_q] = s_data;
      last_d[wr_ptr_q] = s_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    not_full_d = (count_d != 2'd2);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the storage is cleared on reset because outputs must read as zero afterwards.
      data_q     <= '{default: '0};
      last_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      data_q     <= data_d;
      last_q     <= last_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  assign m_data   = data_q[rd_ptr_q];
  assign m_last   = last_q[rd_ptr_q];
  assign m_valid  = (count_q != 2'd0);
  assign not_full = not_full_q;

endmodule

// File: rtl/axis_splitter.sv
// Fans one complex AXI-stream out to every enabled beamformer channel lane.
// The lane mask is frozen for the duration of a frame so no lane sees a partial frame.
module axis_splitter
  import beamformer_pkg::*;
#(
  parameter int SDATA_WIDTH   = beamformer_pkg::SDATA_WIDTH,
  parameter int SSAMPLE_WIDTH = beamformer_pkg::SSAMPLE_WIDTH,
  parameter int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH,
  parameter int NUM_CH        = beamformer_pkg::NUM_CH,
  parameter int FCNT_WIDTH    = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 s_axis_real_tvalid,
  input  logic                                 s_axis_imag_tvalid,
  output logic                                 s_axis_real_tready,
  output logic                                 s_axis_imag_tready,
  input  logic [SDATA_WIDTH-1:0]               s_axis_real_tdata,
  input  logic [SDATA_WIDTH-1:0]               s_axis_imag_tdata,
  input  logic                                 s_axis_real_tlast,
  input  logic                                 s_axis_imag_tlast,
  input  logic [NUM_CH-1:0]                    chan_enable,
  output logic [NUM_CH*SDATA_WIDTH-1:0]        m_axis_real_tdata,
  output logic [NUM_CH*SDATA_WIDTH-1:0]        m_axis_imag_tdata,
  output logic [NUM_CH*(SDATA_WIDTH/8)-1:0]    m_axis_real_tkeep,
  output logic [NUM_CH*(SDATA_WIDTH/8)-1:0]    m_axis_imag_tkeep,
  output logic [NUM_CH-1:0]                    m_axis_real_tlast,
  output logic [NUM_CH-1:0]                    m_axis_imag_tlast,
  output logic [NUM_CH-1:0]                    m_axis_real_tvalid,
  output logic [NUM_CH-1:0]                    m_axis_imag_tvalid,
  input  logic [NUM_CH-1:0]                    m_axis_real_tready,
  input  logic [NUM_CH-1:0]                    m_axis_imag_tready,
  output logic [FCNT_WIDTH-1:0]                frame_count,
  output logic                                 tlast_mismatch
);

  localparam int KEEP_W = SAMPLES * SSAMPLE_WIDTH / 8;

  frame_state_e          state_q, state_d;
  logic [NUM_CH-1:0]     active_mask_q, active_mask_d;
  logic                  started_q, started_d;
  logic [FCNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                  mismatch_q, mismatch_d;

  logic [NUM_CH-1:0]     nf_real, nf_imag;
  logic [NUM_CH-1:0]     push;
  logic                  fork_ready, s_ready, accept;

  // Built only from registered state; an empty mask makes the fork a sink.
  assign fork_ready = &(~active_mask_q | (nf_real & nf_imag));
  // Held off until the mask has been loaded once after reset.
  assign s_ready    = started_q & fork_ready;
  assign accept     = s_axis_real_tvalid & s_axis_imag_tvalid & s_ready;
  assign push       = {NUM_CH{accept}} & active_mask_q;

  always_comb begin
    state_d       = state_q;
    active_mask_d = active_mask_q;
    started_d     = 1'b1;
    frame_count_d = frame_count_q;
    mismatch_d    = mismatch_q;

    if (accept) begin
      if (s_axis_real_tlast) begin
        state_d       = FRAME_IDLE;
        active_mask_d = chan_enable;
        frame_count_d = frame_count_q + FCNT_WIDTH'(1);
      end else begin
        state_d = FRAME_BUSY;
      end
      if (s_axis_real_tlast != s_axis_imag_tlast) begin
        mismatch_d = 1'b1;
      end
    end else if (state_q == FRAME_IDLE) begin
      active_mask_d = chan_enable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FRAME_IDLE;
      active_mask_q <= '0;
      started_q     <= 1'b0;
      frame_count_q <= '0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_mask_q <= active_mask_d;
      started_q     <= started_d;
      frame_count_q <= frame_count_d;
      mismatch_q    <= mismatch_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    axis_skid_buffer #(.DATA_W(SDATA_WIDTH)) u_real (
      .clock    (clock),
      .reset    (reset),
      .s_data   (s_axis_real_tdata),
      .s_last   (s_axis_real_tlast),
      .s_valid  (push[k]),
      .m_data   (m_axis_real_tdata[k*SDATA_WIDTH +: SDATA_WIDTH]),
      .m_last   (m_axis_real_tlast[k]),
      .m_valid  (m_axis_real_tvalid[k]),
      .m_ready  (m_axis_real_tready[k]),
      .not_full (nf_real[k])
    );

    axis_skid_buffer #(.DATA_W(SDATA_WIDTH)) u_imag (
      .clock    (clock),
      .reset    (reset),
      .s_data   (s_axis_imag_tdata),
      .s_last   (s_axis_imag_tlast),
      .s_valid  (push[k]),
      .m_data   (m_axis_imag_tdata[k*SDATA_WIDTH +: SDATA_WIDTH]),
      .m_last   (m_axis_imag_tlast[k]),
      .m_valid  (m_axis_imag_tvalid[k]),
      .m_ready  (m_axis_imag_tready[k]),
      .not_full (nf_imag[k])
    );

    assign m_axis_real_tkeep[k*KEEP_W +: KEEP_W] = m_axis_real_tvalid[k] ? TKEEP_ALL_ONES : '0;
    assign m_axis_imag_tkeep[k*KEEP_W +: KEEP_W] = m_axis_imag_tvalid[k] ? TKEEP_ALL_ONES : '0;
  end

  assign s_axis_real_tready = s_ready;
  assign s_axis_imag_tready = s_ready;
  assign frame_count        = frame_count_q;
  assign tlast_mismatch     = mismatch_q;

endmodule

// File: tb/tb_axis_splitter.sv
// Directed bench for axis_splitter: broadcast, backpressure, frame-aligned masking,
// sink mode, tlast mismatch and mid-frame reset, checked with immediate assertions.
module tb_axis_splitter;
  import beamformer_pkg::*;

  localparam int W  = 128;
  localparam int NC = 4;
  localparam int KW = W / 8;
  localparam int FW = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              s_axis_real_tvalid, s_axis_imag_tvalid;
  logic              s_axis_real_tready, s_axis_imag_tready;
  logic [W-1:0]      s_axis_real_tdata, s_axis_imag_tdata;
  logic              s_axis_real_tlast, s_axis_imag_tlast;
  logic [NC-1:0]     chan_enable;
  logic [NC*W-1:0]   m_axis_real_tdata, m_axis_imag_tdata;
  logic [NC*KW-1:0]  m_axis_real_tkeep, m_axis_imag_tkeep;
  logic [NC-1:0]     m_axis_real_tlast, m_axis_imag_tlast;
  logic [NC-1:0]     m_axis_real_tvalid, m_axis_imag_tvalid;
  logic [NC-1:0]     m_axis_real_tready, m_axis_imag_tready;
  logic [FW-1:0]     frame_count;
  logic              tlast_mismatch;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [W-1:0] got_r  [NC][$];
  logic [W-1:0] got_i  [NC][$];
  logic         got_rl [NC][$];
  logic         got_il [NC][$];
  logic [W-1:0] exp_r [$];
  logic [W-1:0] exp_i [$];
  logic         exp_l [$];

  always #5 clock = ~clock;

  axis_splitter dut (
    .clock              (clock),
    .reset              (reset),
    .s_axis_real_tvalid (s_axis_real_tvalid),
    .s_axis_imag_tvalid (s_axis_imag_tvalid),
    .s_axis_real_tready (s_axis_real_tready),
    .s_axis_imag_tready (s_axis_imag_tready),
    .s_axis_real_tdata  (s_axis_real_tdata),
    .s_axis_imag_tdata  (s_axis_imag_tdata),
    .s_axis_real_tlast  (s_axis_real_tlast),
    .s_axis_imag_tlast  (s_axis_imag_tlast),
    .chan_enable        (chan_enable),
    .m_axis_real_tdata  (m_axis_real_tdata),
    .m_axis_imag_tdata  (m_axis_imag_tdata),
    .m_axis_real_tkeep  (m_axis_real_tkeep),
    .m_axis_imag_tkeep  (m_axis_imag_tkeep),
    .m_axis_real_tlast  (m_axis_real_tlast),
    .m_axis_imag_tlast  (m_axis_imag_tlast),
    .m_axis_real_tvalid (m_axis_real_tvalid),
    .m_axis_imag_tvalid (m_axis_imag_tvalid),
    .m_axis_real_tready (m_axis_real_tready),
    .m_axis_imag_tready (m_axis_imag_tready),
    .frame_count        (frame_count),
    .tlast_mismatch     (tlast_mismatch)
  );

  // Record every beat each lane hands downstream.
  always @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NC; k++) begin
        if (m_axis_real_tvalid[k] && m_axis_real_tready[k]) begin
          got_r[k].push_back(m_axis_real_tdata[k*W +: W]);
          got_rl[k].push_back(m_axis_real_tlast[k]);
        end
        if (m_axis_imag_tvalid[k] && m_axis_imag_tready[k]) begin
          got_i[k].push_back(m_axis_imag_tdata[k*W +: W]);
          got_il[k].push_back(m_axis_imag_tlast[k]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input int base);
    logic [W-1:0] r;
    for (int j = 0; j < 8; j++) r[16*j +: 16] = 16'(base + j);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Present one beat, wait (bounded) until it is accepted, and return the stall count.
  task automatic send_beat(input logic [W-1:0] r, input logic [W-1:0] i,
                           input logic rl, input logic il, output int waited);
    s_axis_real_tdata  = r;
    s_axis_imag_tdata  = i;
    s_axis_real_tlast  = rl;
    s_axis_imag_tlast  = il;
    s_axis_real_tvalid = 1'b1;
    s_axis_imag_tvalid = 1'b1;
    waited = 0;
    while (s_axis_real_tready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 50) begin
      n_asserts++;
      n_fail++;
      $error("FAIL accept_timeout: observed no tready in %0d cycles, required acceptance", waited);
    end else begin
      @(negedge clock);
    end
    s_axis_real_tvalid = 1'b0;
    s_axis_imag_tvalid = 1'b0;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NC; k++) begin
      got_r[k].delete();
      got_i[k].delete();
      got_rl[k].delete();
      got_il[k].delete();
    end
    exp_r.delete();
    exp_i.delete();
    exp_l.delete();
  endtask

  task automatic compare_lane(input int k, input int n, input string tag);
    int bad;
    bad = 0;
    check({tag, "_real_count"}, got_r[k].size(), n);
    check({tag, "_imag_count"}, got_i[k].size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_r[k].size() && (got_r[k][i] !== exp_r[i] || got_rl[k][i] !== exp_l[i])) bad++;
      if (i < got_i[k].size() && (got_i[k][i] !== exp_i[i] || got_il[k][i] !== exp_l[i])) bad++;
    end
    check({tag, "_bad_beats"}, bad, 0);
  endtask

  initial begin
    int w;
    logic [W-1:0] r1, i1;

    reset              = 1'b1;
    s_axis_real_tvalid = 1'b0;
    s_axis_imag_tvalid = 1'b0;
    s_axis_real_tdata  = '0;
    s_axis_imag_tdata  = '0;
    s_axis_real_tlast  = 1'b0;
    s_axis_imag_tlast  = 1'b0;
    chan_enable        = 4'hF;
    m_axis_real_tready = 4'hF;
    m_axis_imag_tready = 4'hF;
    idle(2);

    // Reset state
    check("rst_s_tready", {s_axis_real_tready, s_axis_imag_tready}, 2'b00);
    check("rst_m_tvalid", {m_axis_real_tvalid, m_axis_imag_tvalid}, 8'h00);
    check("rst_m_tdata", m_axis_real_tdata, '0);
    check("rst_frame_count", frame_count, 0);
    check("rst_mismatch", tlast_mismatch, 0);
    reset = 1'b0;
    idle(2);
    check("post_rst_s_tready", s_axis_real_tready, 1);

    // Single-beat broadcast
    r1 = beat(1);
    i1 = 128'h0080_0070_0060_0050_0040_0030_0020_0010;
    send_beat(r1, i1, 1'b1, 1'b1, w);
    check("t1_real_tvalid", m_axis_real_tvalid, 4'hF);
    check("t1_imag_tvalid", m_axis_imag_tvalid, 4'hF);
    check("t1_real_tdata", m_axis_real_tdata, {4{r1}});
    check("t1_imag_tdata", m_axis_imag_tdata, {4{i1}});
    check("t1_real_tkeep", m_axis_real_tkeep, {64{1'b1}});
    check("t1_imag_tkeep", m_axis_imag_tkeep, {64{1'b1}});
    check("t1_tlast", {m_axis_real_tlast, m_axis_imag_tlast}, 8'hFF);
    check("t1_frame_count", frame_count, 1);
    idle(1);
    check("t1_drained", {m_axis_real_tvalid, m_axis_imag_tvalid}, 8'h00);
    check("t1_tkeep_idle", m_axis_real_tkeep, '0);

    // Backpressure on lane CH20 for 5 cycles, 10-beat frame
    clear_all();
    for (int i = 0; i < 10; i++) begin
      exp_r.push_back(beat(16'h0100 + 8 * i));
      exp_i.push_back(beat(16'h4000 + 8 * i));
      exp_l.push_back(i == 9);
    end
    m_axis_real_tready[CH20] = 1'b0;
    m_axis_imag_tready[CH20] = 1'b0;
    fork
      begin
        repeat (5) @(negedge clock);
        m_axis_real_tready[CH20] = 1'b1;
        m_axis_imag_tready[CH20] = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) begin
      send_beat(exp_r[i], exp_i[i], exp_l[i], exp_l[i], w);
      if (i == 1) check("t2_fork_stall", s_axis_real_tready, 0);
      if (i == 2) check("t2_stall_cycles", w, 4);
    end
    idle(5);
    for (int k = 0; k < NC; k++) compare_lane(k, 10, $sformatf("t2_lane%0d", k));
    check("t2_frame_count", frame_count, 2);

    // Mask change mid-frame: 8-beat frame then a 2-beat frame
    clear_all();
    for (int i = 0; i < 8; i++) begin
      exp_r.push_back(beat(16'h0200 + 8 * i));
      exp_i.push_back(beat(16'h5000 + 8 * i));
      exp_l.push_back(i == 7);
    end
    for (int i = 0; i < 2; i++) begin
      exp_r.push_back(beat(16'h0300 + 8 * i));
      exp_i.push_back(beat(16'h6000 + 8 * i));
      exp_l.push_back(i == 1);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) chan_enable = 4'b0001;
      send_beat(exp_r[i], exp_i[i], exp_l[i], exp_l[i], w);
    end
    idle(5);
    compare_lane(CH00, 10, "t3_lane0");
    compare_lane(CH01, 8, "t3_lane1");
    compare_lane(CH20, 8, "t3_lane2");
    compare_lane(CH21, 8, "t3_lane3");
    check("t3_frame_count", frame_count, 4);

    // Sink mode
    clear_all();
    chan_enable = 4'b0000;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      send_beat(beat(16'h0700 + 8 * i), beat(16'h7800 + 8 * i), i == 3, i == 3, w);
      check($sformatf("t4_sink_ready_%0d", i), w, 0);
      check($sformatf("t4_no_tvalid_%0d", i), {m_axis_real_tvalid, m_axis_imag_tvalid}, 8'h00);
    end
    check("t4_frame_count", frame_count, 5);
    check("t4_lane_beats", got_r[0].size() + got_r[1].size() + got_r[2].size() + got_r[3].size(), 0);

    // tlast mismatch is sticky; imag tlast forwarded unchanged
    chan_enable = 4'hF;
    idle(2);
    check("t5_mismatch_before", tlast_mismatch, 0);
    send_beat(beat(16'h0900), beat(16'h9800), 1'b1, 1'b0, w);
    check("t5_mismatch_set", tlast_mismatch, 1);
    check("t5_real_tlast", m_axis_real_tlast, 4'hF);
    check("t5_imag_tlast", m_axis_imag_tlast, 4'h0);
    idle(3);
    check("t5_mismatch_sticky", tlast_mismatch, 1);
    send_beat(beat(16'h0910), beat(16'h9810), 1'b1, 1'b1, w);
    check("t5_mismatch_still", tlast_mismatch, 1);
    check("t5_frame_count", frame_count, 7);

    // Reset mid-frame with beats held in the lanes
    idle(2);
    m_axis_real_tready = 4'h0;
    m_axis_imag_tready = 4'h0;
    send_beat(beat(16'h0A00), beat(16'hA800), 1'b0, 1'b0, w);
    send_beat(beat(16'h0A08), beat(16'hA808), 1'b0, 1'b0, w);
    check("t6_held_tvalid", {m_axis_real_tvalid, m_axis_imag_tvalid}, 8'hFF);
    reset = 1'b1;
    idle(1);
    check("t6_rst_tvalid", {m_axis_real_tvalid, m_axis_imag_tvalid}, 8'h00);
    check("t6_rst_frame_count", frame_count, 0);
    check("t6_rst_mismatch", tlast_mismatch, 0);
    check("t6_rst_s_tready", s_axis_real_tready, 0);
    check("t6_rst_tdata", m_axis_imag_tdata, '0);
    reset = 1'b0;
    m_axis_real_tready = 4'hF;
    m_axis_imag_tready = 4'hF;
    idle(2);
    clear_all();
    exp_r.push_back(beat(16'h0B00));
    exp_i.push_back(beat(16'hB800));
    exp_l.push_back(1'b1);
    send_beat(exp_r[0], exp_i[0], 1'b1, 1'b1, w);
    idle(3);
    for (int k = 0; k < NC; k++) compare_lane(k, 1, $sformatf("t6_lane%0d", k));
    check("t6_frame_count", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
